// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor
//   Passive monitor on a VGA-style pixel stream. Measures line length, active
//   pixels per line, lines per frame and active lines per frame at every
//   vsync assertion. Reports the result with a one-cycle frame_valid pulse and
//   raises locked once the geometry has repeated LOCK_FRAMES times.
//   Lock losses and sync timeouts from the locked state are counted in
//   err_count.
//   Optional feature macro: VGA_MON_CHECKSUM_EN adds a per-frame pixel checksum
//   output, frame_sum.
module vga_timing_monitor #(
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_de,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic [11:0] meas_h_total,
  output logic [11:0] meas_h_active,
  output logic [11:0] meas_v_total,
  output logic [11:0] meas_v_active,
  output logic        frame_valid,
  output logic        locked,
  output logic [7:0]  err_count
`ifdef VGA_MON_CHECKSUM_EN
  ,
  output logic [31:0] frame_sum
`endif
);

  localparam logic [11:0] CNT_MAX     = 12'hFFF;
  localparam logic [3:0]  LOCK_TARGET = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Saturating 12-bit increment used by all geometry counters.
  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + 12'd1;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Sync edge detection
  // ---------------------------------------------------------------------------
  logic w_hs_act;
  logic w_vs_act;
  logic w_hs_edge;
  logic w_vs_edge;
  logic r_hs_prev;
  logic r_vs_prev;

  assign w_hs_act  = (vga_hs == HS_POL);
  assign w_vs_act  = (vga_vs == VS_POL);
  assign w_hs_edge = w_hs_act & ~r_hs_prev;
  assign w_vs_edge = w_vs_act & ~r_vs_prev;

  // ---------------------------------------------------------------------------
  // Line / frame counters
  // ---------------------------------------------------------------------------
  logic [11:0] r_h_cnt;
  logic [11:0] r_de_cnt;
  logic [11:0] r_line_len;
  logic [11:0] r_prev_de;
  logic        r_have_prev;
  logic [11:0] r_last_act_de;
  logic [11:0] r_v_cnt;
  logic [11:0] r_v_act_cnt;
  logic        r_line_bad;

  logic        w_line_active;
  logic        w_line_mismatch;
  logic        w_timeout;

  // A line closes on hs_edge; it is active if it carried any de cycles.
  assign w_line_active   = w_hs_edge && (r_de_cnt != 12'd0);
  assign w_line_mismatch = w_line_active && r_have_prev && (r_de_cnt != r_prev_de);
  assign w_timeout       = (r_h_cnt == CNT_MAX) || (r_v_cnt == CNT_MAX);

  // Frame tuple as seen at this cycle; a line closing together with vs_edge
  // still belongs to the frame that is ending.
  logic [11:0] w_t_h_total;
  logic [11:0] w_t_h_active;
  logic [11:0] w_t_v_total;
  logic [11:0] w_t_v_active;
  logic        w_t_bad;
  logic [47:0] w_tuple;

  assign w_t_h_total  = w_hs_edge ? r_h_cnt : r_line_len;
  assign w_t_h_active = w_line_active ? r_de_cnt : r_last_act_de;
  assign w_t_v_total  = w_hs_edge ? sat_inc12(r_v_cnt) : r_v_cnt;
  assign w_t_v_active = w_line_active ? sat_inc12(r_v_act_cnt) : r_v_act_cnt;
  assign w_t_bad      = r_line_bad | w_line_mismatch;
  assign w_tuple      = {w_t_h_total, w_t_h_active, w_t_v_total, w_t_v_active};

  // Geometry counters: line length, de per line, line counts and consistency.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hs_prev     <= 1'b0;
      r_vs_prev     <= 1'b0;
      r_h_cnt       <= 12'd0;
      r_de_cnt      <= 12'd0;
      r_line_len    <= 12'd0;
      r_prev_de     <= 12'd0;
      r_have_prev   <= 1'b0;
      r_last_act_de <= 12'd0;
      r_v_cnt       <= 12'd0;
      r_v_act_cnt   <= 12'd0;
      r_line_bad    <= 1'b0;
    end else begin
      r_hs_prev <= w_hs_act;
      r_vs_prev <= w_vs_act;

      if (w_hs_edge) begin
        r_line_len <= r_h_cnt;
        r_h_cnt    <= 12'd1;
        r_de_cnt   <= 12'd0;
        r_v_cnt    <= sat_inc12(r_v_cnt);
        if (w_line_active) begin
          r_prev_de     <= r_de_cnt;
          r_have_prev   <= 1'b1;
          r_last_act_de <= r_de_cnt;
          r_v_act_cnt   <= sat_inc12(r_v_act_cnt);
        end
        if (w_line_mismatch) begin
          r_line_bad <= 1'b1;
        end
      end else begin
        r_h_cnt <= sat_inc12(r_h_cnt);
        if (vga_de) begin
          r_de_cnt <= sat_inc12(r_de_cnt);
        end
      end

      // Frame boundary: start a fresh frame (overrides the line updates above).
      if (w_vs_edge) begin
        r_v_cnt       <= 12'd0;
        r_v_act_cnt   <= 12'd0;
        r_line_bad    <= 1'b0;
        r_have_prev   <= 1'b0;
        r_last_act_de <= 12'd0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Lock FSM
  // ---------------------------------------------------------------------------
  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_match_cnt;
  logic [3:0]  w_match_next;
  logic [3:0]  w_match_inc;
  logic [47:0] r_prev_t;
  logic        r_prev_valid;
  logic        w_prev_valid_next;
  logic        w_t_same;
  logic        w_capture;
  logic        w_locked_next;
  logic        w_err_inc;
  logic [7:0]  w_err_next;

  logic [11:0] r_meas_h_total;
  logic [11:0] r_meas_h_active;
  logic [11:0] r_meas_v_total;
  logic [11:0] r_meas_v_active;
  logic        r_frame_valid;
  logic        r_locked;
  logic [7:0]  r_err_count;

  assign w_t_same    = r_prev_valid && (w_tuple == r_prev_t) && !w_t_bad;
  assign w_match_inc = (r_match_cnt == 4'hF) ? r_match_cnt : (r_match_cnt + 4'd1);
  assign w_err_next  = (w_err_inc && (r_err_count != 8'hFF)) ? (r_err_count + 8'd1) : r_err_count;

  // Next-state and capture decisions for the lock FSM.
  always_comb begin
    w_state_next      = r_state;
    w_match_next      = r_match_cnt;
    w_prev_valid_next = r_prev_valid;
    w_capture         = 1'b0;
    w_locked_next     = r_locked;
    w_err_inc         = 1'b0;

    if (w_timeout) begin
      // Sync has stopped: drop back to IDLE, the next frame is partial again.
      w_state_next      = ST_IDLE;
      w_locked_next     = 1'b0;
      w_match_next      = 4'd0;
      w_prev_valid_next = 1'b0;
      w_err_inc         = (r_state == ST_LOCKED);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_vs_edge) begin
            w_state_next = ST_MEASURE;
            w_match_next = 4'd0;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
        ST_MEASURE: begin
          if (w_vs_edge) begin
            w_capture         = 1'b1;
            w_prev_valid_next = 1'b1;
            if (w_t_same) begin
              w_match_next = w_match_inc;
              if (w_match_inc >= LOCK_TARGET) begin
                w_state_next  = ST_LOCKED;
                w_locked_next = 1'b1;
              end else begin
                w_state_next = ST_MEASURE;
              end
            end else begin
              w_match_next = 4'd0;
            end
          end else begin
            w_state_next = ST_MEASURE;
          end
        end
        ST_LOCKED: begin
          if (w_vs_edge) begin
            w_capture         = 1'b1;
            w_prev_valid_next = 1'b1;
            if (!w_t_same) begin
              w_state_next  = ST_MEASURE;
              w_locked_next = 1'b0;
              w_match_next  = 4'd0;
              w_err_inc     = 1'b1;
            end else begin
              w_state_next = ST_LOCKED;
            end
          end else begin
            w_state_next = ST_LOCKED;
          end
        end
        default: begin
          w_state_next      = ST_IDLE;
          w_locked_next     = 1'b0;
          w_match_next      = 4'd0;
          w_prev_valid_next = 1'b0;
        end
      endcase
    end
  end

  // FSM state, lock bookkeeping and registered measurement outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_match_cnt     <= 4'd0;
      r_prev_t        <= 48'd0;
      r_prev_valid    <= 1'b0;
      r_meas_h_total  <= 12'd0;
      r_meas_h_active <= 12'd0;
      r_meas_v_total  <= 12'd0;
      r_meas_v_active <= 12'd0;
      r_frame_valid   <= 1'b0;
      r_locked        <= 1'b0;
      r_err_count     <= 8'd0;
    end else begin
      r_state       <= w_state_next;
      r_match_cnt   <= w_match_next;
      r_prev_valid  <= w_prev_valid_next;
      r_frame_valid <= w_capture;
      r_locked      <= w_locked_next;
      r_err_count   <= w_err_next;
      if (w_capture) begin
        r_prev_t        <= w_tuple;
        r_meas_h_total  <= w_t_h_total;
        r_meas_h_active <= w_t_h_active;
        r_meas_v_total  <= w_t_v_total;
        r_meas_v_active <= w_t_v_active;
      end
    end
  end

  assign meas_h_total  = r_meas_h_total;
  assign meas_h_active = r_meas_h_active;
  assign meas_v_total  = r_meas_v_total;
  assign meas_v_active = r_meas_v_active;
  assign frame_valid   = r_frame_valid;
  assign locked        = r_locked;
  assign err_count     = r_err_count;

  // ---------------------------------------------------------------------------
  // Optional per-frame pixel checksum
  // ---------------------------------------------------------------------------
`ifdef VGA_MON_CHECKSUM_EN
  logic [31:0] r_acc;
  logic [31:0] w_acc_now;
  logic [31:0] r_frame_sum;

  // A de pixel coinciding with vs_edge is still part of the ending frame.
  assign w_acc_now = r_acc + (vga_de ? {8'h00, vga_r, vga_g, vga_b} : 32'd0);

  // Accumulate de pixels; restart at each frame and publish with meas_*.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc       <= 32'd0;
      r_frame_sum <= 32'd0;
    end else begin
      if (w_vs_edge) begin
        r_acc <= 32'd0;
      end else begin
        r_acc <= w_acc_now;
      end
      if (w_capture) begin
        r_frame_sum <= w_acc_now;
      end
    end
  end

  assign frame_sum = r_frame_sum;
`else
  // Pixel data is only consumed by the checksum; tie it off here.
  logic w_unused_pix;
  assign w_unused_pix = ^{vga_r, vga_g, vga_b};
`endif

endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor
//   Drives a scaled-down VGA stream (small geometry keeps frames short) into
//   vga_timing_monitor. At each driven vsync assertion the expected frame
//   tuple, lock state and error count are queued; they are popped and compared
//   when frame_valid fires. Build with VGA_MON_CHECKSUM_EN to also check
//   frame_sum against a checksum accumulated from the driven pixels.
module tb_vga_timing_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_de;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic [11:0] meas_h_total;
  logic [11:0] meas_h_active;
  logic [11:0] meas_v_total;
  logic [11:0] meas_v_active;
  logic        frame_valid;
  logic        locked;
  logic [7:0]  err_count;
`ifdef VGA_MON_CHECKSUM_EN
  logic [31:0] frame_sum;
`endif

  always #5 clk = ~clk;

  vga_timing_monitor dut (
    .clk          (clk),
    .reset        (reset),
    .vga_hs       (vga_hs),
    .vga_vs       (vga_vs),
    .vga_de       (vga_de),
    .vga_r        (vga_r),
    .vga_g        (vga_g),
    .vga_b        (vga_b),
    .meas_h_total (meas_h_total),
    .meas_h_active(meas_h_active),
    .meas_v_total (meas_v_total),
    .meas_v_active(meas_v_active),
    .frame_valid  (frame_valid),
    .locked       (locked),
    .err_count    (err_count)
`ifdef VGA_MON_CHECKSUM_EN
    ,
    .frame_sum    (frame_sum)
`endif
  );

  typedef struct {
    logic [11:0] ht;
    logic [11:0] ha;
    logic [11:0] vt;
    logic [11:0] va;
    logic        lk;
    logic [7:0]  err;
    logic [31:0] sum;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Stream geometry and per-frame expectations (written by the test tasks).
  int   g_htot, g_hact, g_hs_col, g_hs_w, g_vtot, g_vact, g_vs_line, g_vs_col;
  int   g_bad_line = -1;
  bit   g_fv_exp   = 1'b0;
  bit   g_lock_exp = 1'b0;
  int   g_err_exp  = 0;
  logic [31:0] model_acc = 32'd0;

  // Drive one pixel clock, then compare any frame_valid against the scoreboard.
  task automatic step(input logic hs_a, input logic vs_a, input logic de,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic vs_edge);
    exp_t e;
    vga_hs = hs_a ? 1'b0 : 1'b1;
    vga_vs = vs_a ? 1'b0 : 1'b1;
    vga_de = de;
    vga_r  = r;
    vga_g  = g;
    vga_b  = b;
    if (de) model_acc = model_acc + {8'h00, r, g, b};
    if (vs_edge) begin
      if (g_fv_exp) begin
        e.ht  = g_htot[11:0];
        e.ha  = g_hact[11:0];
        e.vt  = g_vtot[11:0];
        e.va  = g_vact[11:0];
        e.lk  = g_lock_exp;
        e.err = g_err_exp[7:0];
        e.sum = model_acc;
        sb_q.push_back(e);
      end
      model_acc = 32'd0;
    end
    @(posedge clk);
    @(negedge clk);
    if (frame_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_frame_valid: got 1, wanted 0 at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        n_checks++;
        if (meas_h_total !== e.ht) begin
          n_fail++;
          $display("FAIL h_total: got %0d, wanted %0d", meas_h_total, e.ht);
        end
        n_checks++;
        if (meas_h_active !== e.ha) begin
          n_fail++;
          $display("FAIL h_active: got %0d, wanted %0d", meas_h_active, e.ha);
        end
        n_checks++;
        if (meas_v_total !== e.vt) begin
          n_fail++;
          $display("FAIL v_total: got %0d, wanted %0d", meas_v_total, e.vt);
        end
        n_checks++;
        if (meas_v_active !== e.va) begin
          n_fail++;
          $display("FAIL v_active: got %0d, wanted %0d", meas_v_active, e.va);
        end
        n_checks++;
        if (locked !== e.lk) begin
          n_fail++;
          $display("FAIL locked_at_frame: got %0b, wanted %0b at %0t", locked, e.lk, $time);
        end
        n_checks++;
        if (err_count !== e.err) begin
          n_fail++;
          $display("FAIL err_at_frame: got %0d, wanted %0d", err_count, e.err);
        end
`ifdef VGA_MON_CHECKSUM_EN
        n_checks++;
        if (frame_sum !== e.sum) begin
          n_fail++;
          $display("FAIL frame_sum: got %h, wanted %h", frame_sum, e.sum);
        end
`endif
      end
    end else if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL missing_frame_valid: got 0, wanted 1 at %0t", $time);
      void'(sb_q.pop_front());
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic drive_line(input int line);
    int   vs_start;
    int   p;
    int   de_len;
    logic hs_a, vs_a, de, vse;
    vs_start = g_vs_line * g_htot + g_vs_col;
    de_len   = (line == g_bad_line) ? g_hact - 1 : g_hact;
    for (int col = 0; col < g_htot; col++) begin
      p    = line * g_htot + col;
      hs_a = (col >= g_hs_col) && (col < g_hs_col + g_hs_w);
      vs_a = (p >= vs_start) && (p < vs_start + 2 * g_htot);
      vse  = (p == vs_start);
      de   = (line < g_vact) && (col < de_len);
      step(hs_a, vs_a, de, line[7:0], col[7:0], 8'h5A, vse);
    end
  endtask

  task automatic run_lines(input int first, input int last);
    for (int l = first; l <= last; l++) drive_line(l);
  endtask

  task automatic frame(input bit fv, input bit lk, input int err);
    g_fv_exp   = fv;
    g_lock_exp = lk;
    g_err_exp  = err;
    run_lines(0, g_vtot - 1);
  endtask

  task automatic set_geom_a();
    g_htot = 48; g_hact = 32; g_hs_col = 36; g_hs_w = 4;
    g_vtot = 14; g_vact = 10; g_vs_line = 11; g_vs_col = 0;
  endtask

  task automatic set_geom_b();
    g_htot = 60; g_hact = 44; g_hs_col = 50; g_hs_w = 5;
    g_vtot = 20; g_vact = 15; g_vs_line = 17; g_vs_col = 50;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_cycles(3);
    n_checks++; if (meas_h_total !== 12'd0)  begin n_fail++; $display("FAIL reset_h_total: got %0d, wanted 0", meas_h_total); end
    n_checks++; if (meas_h_active !== 12'd0) begin n_fail++; $display("FAIL reset_h_active: got %0d, wanted 0", meas_h_active); end
    n_checks++; if (meas_v_total !== 12'd0)  begin n_fail++; $display("FAIL reset_v_total: got %0d, wanted 0", meas_v_total); end
    n_checks++; if (meas_v_active !== 12'd0) begin n_fail++; $display("FAIL reset_v_active: got %0d, wanted 0", meas_v_active); end
    n_checks++; if (frame_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_frame_valid: got %0b, wanted 0", frame_valid); end
    n_checks++; if (locked !== 1'b0)         begin n_fail++; $display("FAIL reset_locked: got %0b, wanted 0", locked); end
    n_checks++; if (err_count !== 8'd0)      begin n_fail++; $display("FAIL reset_err: got %0d, wanted 0", err_count); end
    reset = 1'b0;
    idle_cycles(2);
  endtask

  // Discard frame, then lock on the third measured frame and hold.
  task automatic test_lock();
    set_geom_a();
    g_bad_line = -1;
    frame(1'b0, 1'b0, 0);
    frame(1'b1, 1'b0, 0);
    frame(1'b1, 1'b0, 0);
    frame(1'b1, 1'b1, 0);
    frame(1'b1, 1'b1, 0);
    n_checks++; if (locked !== 1'b1)    begin n_fail++; $display("FAIL lock_hold: got %0b, wanted 1", locked); end
    n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL lock_err: got %0d, wanted 0", err_count); end
  endtask

  // One short line drops lock; two clean frames re-acquire it.
  task automatic test_bad_line();
    g_bad_line = 4;
    frame(1'b1, 1'b0, 1);
    g_bad_line = -1;
    frame(1'b1, 1'b0, 1);
    frame(1'b1, 1'b1, 1);
    n_checks++; if (locked !== 1'b1)    begin n_fail++; $display("FAIL relock: got %0b, wanted 1", locked); end
    n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL bad_line_err: got %0d, wanted 1", err_count); end
  endtask

  // Sync stops long enough for the line counter to saturate.
  task automatic test_timeout();
    idle_cycles(4200);
    n_checks++; if (locked !== 1'b0)       begin n_fail++; $display("FAIL timeout_locked: got %0b, wanted 0", locked); end
    n_checks++; if (err_count !== 8'd2)    begin n_fail++; $display("FAIL timeout_err: got %0d, wanted 2", err_count); end
    n_checks++; if (meas_v_total !== 12'd14) begin n_fail++; $display("FAIL timeout_meas_hold: got %0d, wanted 14", meas_v_total); end
    frame(1'b0, 1'b0, 2);
    frame(1'b1, 1'b0, 2);
    frame(1'b1, 1'b0, 2);
    frame(1'b1, 1'b1, 2);
  endtask

  // One-cycle reset inside a frame restarts the whole acquisition.
  task automatic test_reset_midframe();
    g_fv_exp = 1'b0;
    run_lines(0, 4);
    reset = 1'b1;
    idle_cycles(1);
    reset = 1'b0;
    n_checks++; if (meas_h_total !== 12'd0) begin n_fail++; $display("FAIL midrst_h_total: got %0d, wanted 0", meas_h_total); end
    n_checks++; if (meas_v_total !== 12'd0) begin n_fail++; $display("FAIL midrst_v_total: got %0d, wanted 0", meas_v_total); end
    n_checks++; if (locked !== 1'b0)        begin n_fail++; $display("FAIL midrst_locked: got %0b, wanted 0", locked); end
    n_checks++; if (err_count !== 8'd0)     begin n_fail++; $display("FAIL midrst_err: got %0d, wanted 0", err_count); end
    g_fv_exp = 1'b0;
    run_lines(5, g_vtot - 1);
    frame(1'b1, 1'b0, 0);
    frame(1'b1, 1'b0, 0);
    frame(1'b1, 1'b1, 0);
  endtask

  // Different geometry with hs and vs asserting in the same cycle.
  task automatic test_coincident_b();
    reset = 1'b1;
    idle_cycles(2);
    reset = 1'b0;
    set_geom_b();
    frame(1'b0, 1'b0, 0);
    frame(1'b1, 1'b0, 0);
    frame(1'b1, 1'b0, 0);
    frame(1'b1, 1'b1, 0);
    n_checks++; if (meas_v_total !== 12'd20) begin n_fail++; $display("FAIL coincident_v_total: got %0d, wanted 20", meas_v_total); end
  endtask

  initial begin
    reset  = 1'b1;
    vga_hs = 1'b1;
    vga_vs = 1'b1;
    vga_de = 1'b0;
    vga_r  = 8'h00;
    vga_g  = 8'h00;
    vga_b  = 8'h00;
    @(negedge clk);
    test_reset();
    test_lock();
    test_bad_line();
    test_timeout();
    test_reset_midframe();
    test_coincident_b();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, wanted 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
